// File: rtl/ir_nec_tx.sv
// NEC infrared frame transmitter: data or repeat frames from a valid/ready request,
// with a 38 kHz modulated LED drive and a raw envelope for receiver loop-back.
module ir_nec_tx #(
  parameter int unsigned UNIT_CYC   = 28125,
  parameter int unsigned CAR_DIV    = 1316,
  parameter int unsigned CAR_HIGH   = 439,
  parameter int unsigned TAIL_UNITS = 72
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_repeat,
  input  logic [7:0] in_addr,
  input  logic [7:0] in_cmd,
  output logic       ir_out,
  output logic       ir_env,
  output logic       busy,
  output logic       done
);

  localparam int unsigned UNIT_W  = $clog2(UNIT_CYC + 1);
  localparam int unsigned PH_W    = $clog2(CAR_DIV + 1);
  localparam int unsigned MAX_LEN = (TAIL_UNITS > 16) ? TAIL_UNITS : 16;
  localparam int unsigned TALLY_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_TAIL
  } state_t;

  state_t             state, state_nxt;
  logic [UNIT_W-1:0]  unit_cnt, unit_nxt;
  logic [TALLY_W-1:0] tally, tally_nxt, len;
  logic [4:0]         bit_idx, bit_nxt;
  logic [31:0]        shreg, sh_nxt;
  logic               rpt, rpt_nxt;
  logic [PH_W-1:0]    phase, phase_nxt;
  logic               unit_end, state_end, mark_nxt;

  // Next-state, counters and carrier phase
  always_comb begin
    state_nxt = state;
    unit_nxt  = unit_cnt;
    tally_nxt = tally;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    rpt_nxt   = rpt;
    len       = TALLY_W'(1);

    case (state)
      S_LEAD_MARK:  len = TALLY_W'(16);
      S_LEAD_SPACE: len = rpt ? TALLY_W'(4) : TALLY_W'(8);
      S_BIT_SPACE:  len = shreg[0] ? TALLY_W'(3) : TALLY_W'(1);
      S_TAIL:       len = TALLY_W'(TAIL_UNITS);
      default:      len = TALLY_W'(1);
    endcase

    unit_end  = (unit_cnt == UNIT_W'(UNIT_CYC - 1));
    state_end = unit_end && (tally == len - TALLY_W'(1));

    if (state == S_IDLE) begin
      if (in_valid) begin
        state_nxt = S_LEAD_MARK;
        sh_nxt    = {~in_cmd, in_cmd, ~in_addr, in_addr};
        rpt_nxt   = in_repeat;
        bit_nxt   = 5'd0;
        unit_nxt  = '0;
        tally_nxt = '0;
      end
    end else if (state_end) begin
      unit_nxt  = '0;
      tally_nxt = '0;
      case (state)
        S_LEAD_MARK:  state_nxt = S_LEAD_SPACE;
        S_LEAD_SPACE: state_nxt = rpt ? S_STOP_MARK : S_BIT_MARK;
        S_BIT_MARK:   state_nxt = S_BIT_SPACE;
        S_BIT_SPACE: begin
          if (bit_idx == 5'd31) begin
            state_nxt = S_STOP_MARK;
          end else begin
            state_nxt = S_BIT_MARK;
            sh_nxt    = {1'b0, shreg[31:1]};
            bit_nxt   = bit_idx + 5'd1;
          end
        end
        S_STOP_MARK:  state_nxt = (TAIL_UNITS > 0) ? S_TAIL : S_IDLE;
        default:      state_nxt = S_IDLE;
      endcase
    end else if (unit_end) begin
      unit_nxt  = '0;
      tally_nxt = tally + TALLY_W'(1);
    end else begin
      unit_nxt = unit_cnt + UNIT_W'(1);
    end

    // Restarting on every state change makes each mark begin carrier-high
    if (state_nxt != state) begin
      phase_nxt = '0;
    end else if (phase == PH_W'(CAR_DIV - 1)) begin
      phase_nxt = '0;
    end else begin
      phase_nxt = phase + PH_W'(1);
    end

    mark_nxt = (state_nxt == S_LEAD_MARK) || (state_nxt == S_BIT_MARK) ||
               (state_nxt == S_STOP_MARK);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      unit_cnt <= '0;
      tally    <= '0;
      bit_idx  <= 5'd0;
      shreg    <= '0;
      rpt      <= 1'b0;
      phase    <= '0;
      ir_out   <= 1'b0;
      ir_env   <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      unit_cnt <= unit_nxt;
      tally    <= tally_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= sh_nxt;
      rpt      <= rpt_nxt;
      phase    <= phase_nxt;
      ir_env   <= mark_nxt;
      ir_out   <= mark_nxt && (phase_nxt < PH_W'(CAR_HIGH));
      in_ready <= (state_nxt == S_IDLE);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state != S_IDLE) && (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed bench for ir_nec_tx: records the envelope of each frame, decodes mark/space
// run lengths and checks timing, payload, carrier pattern, reset and handshake.
module tb_ir_nec_tx;

  localparam int LIMIT = 700;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_repeat, ir_out, ir_env, busy, done;
  logic [7:0] in_addr, in_cmd;

  int n_total = 0;
  int n_bad   = 0;

  bit env_q [0:LIMIT-1];
  bit out_q [0:LIMIT-1];
  int runs  [0:79];

  ir_nec_tx #(.UNIT_CYC(4), .CAR_DIV(3), .CAR_HIGH(1), .TAIL_UNITS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_repeat(in_repeat), .in_addr(in_addr), .in_cmd(in_cmd),
    .ir_out(ir_out), .ir_env(ir_env), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample every cycle after an accept edge until done (k = edges since accept)
  task automatic capture(input bit hold, input bit mutate, output int dk);
    bit seen;
    seen = 1'b0;
    dk   = LIMIT;
    for (int k = 0; k < LIMIT; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (k == 0) begin
          in_valid = hold;
          chk("ready_drop", {31'd0, in_ready}, 32'd0);
        end
        if (mutate && k == 10) begin
          in_addr = 8'h56;
          in_cmd  = 8'h78;
        end
        env_q[k] = ir_env;
        out_q[k] = ir_out;
        if (done) begin
          dk   = k;
          seen = 1'b1;
        end
      end
    end
  endtask

  task automatic analyze(input bit rpt, input logic [31:0] exp_word, input int dk);
    int nr, len, pos, car_err, mark_err, sp_err;
    logic [31:0] word;
    bit exp_out;
    chk("done_latency", dk, rpt ? 32'd92 : 32'd492);
    for (int i = 0; i < 80; i++) runs[i] = 0;
    nr = 0; len = 0; pos = 0; car_err = 0;
    for (int k = 0; k < dk && k < LIMIT; k++) begin
      if (k > 0 && env_q[k] != env_q[k-1]) begin
        if (nr < 80) runs[nr] = len;
        nr++;
        len = 0;
      end
      len++;
      if (env_q[k]) begin
        pos = (k == 0 || !env_q[k-1]) ? 0 : pos + 1;
        exp_out = (pos % 3 == 0);
      end else begin
        exp_out = 1'b0;
      end
      if (out_q[k] != exp_out) car_err++;
    end
    if (nr < 80) runs[nr] = len;
    nr++;
    chk("first_is_mark", {31'd0, env_q[0]}, 32'd1);
    chk("carrier", car_err, 0);
    chk("run_count", nr, rpt ? 32'd4 : 32'd68);
    chk("lead_mark", runs[0], 64);
    chk("lead_space", runs[1], rpt ? 32'd16 : 32'd32);
    if (rpt) begin
      chk("stop_mark", runs[2], 4);
      chk("tail", runs[3], 8);
    end else begin
      word = '0; mark_err = 0; sp_err = 0;
      for (int i = 0; i < 32; i++) begin
        if (runs[2 + 2*i] != 4) mark_err++;
        if (runs[3 + 2*i] == 12) word[i] = 1'b1;
        else if (runs[3 + 2*i] != 4) sp_err++;
      end
      chk("bit_marks", mark_err, 0);
      chk("bit_spaces", sp_err, 0);
      chk("payload", word, exp_word);
      chk("stop_mark", runs[66], 4);
      chk("tail", runs[67], 8);
    end
  endtask

  task automatic run_frame(input bit rpt, input logic [7:0] a, input logic [7:0] c,
                           input logic [31:0] exp_word);
    int dk;
    @(negedge clk);
    in_valid = 1'b1; in_repeat = rpt; in_addr = a; in_cmd = c;
    chk("ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    capture(1'b0, 1'b0, dk);
    analyze(rpt, exp_word, dk);
    @(negedge clk);
    chk("done_single", {31'd0, done}, 32'd0);
    chk("ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int dk;
    rst = 1'b1; in_valid = 1'b0; in_repeat = 1'b0; in_addr = 8'h00; in_cmd = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_env", {31'd0, ir_env}, 32'd0);

    // Reset in the middle of a frame
    in_valid = 1'b1; in_addr = 8'h33; in_cmd = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_started", {31'd0, busy}, 32'd1);
    repeat (50) @(negedge clk);
    chk("mid_env", {31'd0, ir_env}, 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("abort_out", {31'd0, ir_out}, 32'd0);
    chk("abort_env", {31'd0, ir_env}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("abort_stays_idle", {31'd0, ir_env}, 32'd0);

    run_frame(1'b0, 8'h00, 8'h00, 32'hFF00_FF00);
    run_frame(1'b0, 8'h04, 8'h08, 32'hF708_FB04);
    run_frame(1'b1, 8'hAA, 8'h00, 32'h0);

    // in_valid held high: fields changed mid-frame only affect the next frame
    @(negedge clk);
    in_valid = 1'b1; in_repeat = 1'b0; in_addr = 8'h12; in_cmd = 8'h34;
    @(posedge clk);
    capture(1'b1, 1'b1, dk);
    chk("b2b_done_ready", {31'd0, in_ready}, 32'd1);
    analyze(1'b0, 32'hCB34_ED12, dk);
    @(posedge clk);
    capture(1'b0, 1'b0, dk);
    analyze(1'b0, 32'h8778_A956, dk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
